// File: rtl/aes_sched_pkg.sv
// Shared state and mode encodings for the AES job scheduler.
package aes_sched_pkg;

    typedef enum logic [2:0] {IDLE, KEY, START, WAIT, OUT} state_t;
    typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_t;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-Stream bundle (tdata/tvalid/tready) with source and sink views.
interface taxi_axis_if #(
    parameter int DATA_W = 128
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, output tvalid, input tready);
    modport snk (input tdata, input tvalid, output tready);

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: the pointer favours the side not served last.
module aes_rr_arb2
    import aes_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  mode_t      served,
    output logic [1:0] grant
);

    mode_t ptr_reg;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (ptr_reg == ENC || !req[1])) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= ENC;
        end else if (update) begin
            ptr_reg <= (served == ENC) ? DEC : ENC;
        end
    end

endmodule

// File: rtl/aes_engine_sched.sv
// Schedules encrypt/decrypt jobs and key expansions onto one shared AES engine.
// Optional watchdog on engine completion: define AES_SCHED_TIMEOUT_EN.
module aes_engine_sched
    import aes_sched_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    taxi_axis_if.snk          s_axis_enc,
    taxi_axis_if.snk          s_axis_dec,
    taxi_axis_if.src          m_axis_enc,
    taxi_axis_if.src          m_axis_dec,
    input  logic              i_ekey_update,
    input  logic              i_dkey_update,
    output logic              o_eng_start,
    output logic              o_eng_dec,
    output logic [DATA_W-1:0] o_eng_din,
    output logic              o_eng_ekey_load,
    output logic              o_eng_dkey_load,
    input  logic              i_eng_done,
    input  logic [DATA_W-1:0] i_eng_dout,
`ifdef AES_SCHED_TIMEOUT_EN
    output logic              o_timeout,
`endif
    output logic              o_busy
);

    state_t            state_reg;
    mode_t             mode_reg;
    logic [DATA_W-1:0] din_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              start_reg;
    logic              ekey_load_reg;
    logic              dkey_load_reg;
    logic              out_valid_reg;
    logic              ekey_pend_reg;
    logic              dkey_pend_reg;
    logic              key_pend;
    logic              grant_en;
    logic [1:0]        grant;
    logic              out_hs;
    logic              tmo_hit;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    // An update pulse coinciding with its own load pulse wins, so no update is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ekey_pend_reg <= 1'b0;
            dkey_pend_reg <= 1'b0;
        end else begin
            ekey_pend_reg <= i_ekey_update | (ekey_pend_reg & ~ekey_load_reg);
            dkey_pend_reg <= i_dkey_update | (dkey_pend_reg & ~dkey_load_reg);
        end
    end

    assign key_pend = ekey_pend_reg | dkey_pend_reg;
    assign grant_en = (state_reg == IDLE) && !key_pend;

    aes_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({s_axis_dec.tvalid, s_axis_enc.tvalid}),
        .update (out_hs),
        .served (mode_reg),
        .grant  (grant)
    );

    assign s_axis_enc.tready = grant_en & grant[0];
    assign s_axis_dec.tready = grant_en & grant[1];

    assign out_hs = (state_reg == OUT) &&
                    ((mode_reg == ENC) ? m_axis_enc.tready : m_axis_dec.tready);

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             timeout_reg;

    // Counts cycles spent in the current KEY/WAIT visit; every visit starts from IDLE or START.
    always_ff @(posedge clk) begin
        if (rst || !(state_reg == WAIT || state_reg == KEY)) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else if (tmo_hit && !i_eng_done && (state_reg == WAIT || state_reg == KEY)) begin
            timeout_reg <= 1'b1;
        end
    end

    assign o_timeout = timeout_reg;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= ENC;
            din_reg       <= '0;
            dout_reg      <= '0;
            start_reg     <= 1'b0;
            ekey_load_reg <= 1'b0;
            dkey_load_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            start_reg     <= 1'b0;
            ekey_load_reg <= 1'b0;
            dkey_load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ekey_pend_reg) begin
                        ekey_load_reg <= 1'b1;
                        state_reg     <= KEY;
                    end else if (dkey_pend_reg) begin
                        dkey_load_reg <= 1'b1;
                        state_reg     <= KEY;
                    end else if (s_axis_enc.tready) begin
                        din_reg   <= s_axis_enc.tdata;
                        mode_reg  <= ENC;
                        start_reg <= 1'b1;
                        state_reg <= START;
                    end else if (s_axis_dec.tready) begin
                        din_reg   <= s_axis_dec.tdata;
                        mode_reg  <= DEC;
                        start_reg <= 1'b1;
                        state_reg <= START;
                    end
                end
                KEY: begin
                    if (i_eng_done || tmo_hit) begin
                        state_reg <= IDLE;
                    end
                end
                START: state_reg <= WAIT;
                WAIT: begin
                    if (i_eng_done) begin
                        dout_reg      <= i_eng_dout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= OUT;
                    end else if (tmo_hit) begin
                        state_reg <= IDLE;
                    end
                end
                OUT: begin
                    if (out_hs) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_axis_enc.tvalid = out_valid_reg && (mode_reg == ENC);
    assign m_axis_dec.tvalid = out_valid_reg && (mode_reg == DEC);
    assign m_axis_enc.tdata  = dout_reg;
    assign m_axis_dec.tdata  = dout_reg;

    assign o_eng_start     = start_reg;
    assign o_eng_dec       = (mode_reg == DEC);
    assign o_eng_din       = din_reg;
    assign o_eng_ekey_load = ekey_load_reg;
    assign o_eng_dkey_load = dkey_load_reg;
    assign o_busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_engine_sched.sv
// Directed bench for aes_engine_sched with a fixed-latency AES engine model.
// Build with AES_SCHED_TIMEOUT_EN defined to also exercise the watchdog.
module tb_aes_engine_sched;

    localparam int          DW      = 128;
    localparam int          ENG_LAT = 10;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Event codes logged by the monitor, one hex nibble each.
    localparam int EV_GE = 1, EV_GD = 2, EV_EK = 3, EV_DK = 4, EV_OE = 5, EV_OD = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ekey_upd = 1'b0;
    logic          dkey_upd = 1'b0;
    logic          eng_start, eng_dec, eng_ekey_load, eng_dkey_load, busy;
    logic [DW-1:0] eng_din;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_dout = '0;
    logic [DW-1:0] eng_res  = '0;
    int            eng_cnt  = 0;
    bit            eng_mute = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
    logic          timeout;
`endif

    taxi_axis_if #(.DATA_W(DW)) enc_in (), dec_in (), enc_out (), dec_out ();

    int total = 0;
    int bad   = 0;
    int ev_q[$];
    int ev_base = 0;

    typedef struct {
        logic         dec;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    aes_engine_sched #(.DATA_W(DW), .TIMEOUT_CYC(64)) dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis_enc      (enc_in),
        .s_axis_dec      (dec_in),
        .m_axis_enc      (enc_out),
        .m_axis_dec      (dec_out),
        .i_ekey_update   (ekey_upd),
        .i_dkey_update   (dkey_upd),
        .o_eng_start     (eng_start),
        .o_eng_dec       (eng_dec),
        .o_eng_din       (eng_din),
        .o_eng_ekey_load (eng_ekey_load),
        .o_eng_dkey_load (eng_dkey_load),
        .i_eng_done      (eng_done),
        .i_eng_dout      (eng_dout),
`ifdef AES_SCHED_TIMEOUT_EN
        .o_timeout       (timeout),
`endif
        .o_busy          (busy)
    );

    function automatic logic [127:0] eng_func(input logic dec, input logic [127:0] d);
        if (!dec && d == PT) return CT;
        if (dec && d == CT) return PT;
        return dec ? ~d : (d ^ {16{8'ha5}});
    endfunction

    // Engine: done pulses ENG_LAT cycles after a start or key-load cycle; not reset by rst.
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_dout <= eng_res;
            end
        end else if (!eng_mute && (eng_start || eng_ekey_load || eng_dkey_load)) begin
            eng_cnt <= ENG_LAT - 1;
            eng_res <= eng_func(eng_dec, eng_din);
        end
    end

    always @(posedge clk) begin
        if (enc_in.tvalid && enc_in.tready) begin
            ev_q.push_back(EV_GE);
            $display("%0t: grant enc din=%h", $time, enc_in.tdata);
        end
        if (dec_in.tvalid && dec_in.tready) begin
            ev_q.push_back(EV_GD);
            $display("%0t: grant dec din=%h", $time, dec_in.tdata);
        end
        if (eng_ekey_load) begin
            ev_q.push_back(EV_EK);
            $display("%0t: ekey load", $time);
        end
        if (eng_dkey_load) begin
            ev_q.push_back(EV_DK);
            $display("%0t: dkey load", $time);
        end
        if (enc_out.tvalid && enc_out.tready) begin
            ev_q.push_back(EV_OE);
            $display("%0t: result enc dout=%h", $time, enc_out.tdata);
        end
        if (dec_out.tvalid && dec_out.tready) begin
            ev_q.push_back(EV_OD);
            $display("%0t: result dec dout=%h", $time, dec_out.tdata);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired, got no event, required one", name);
    endtask

    function automatic logic [31:0] ev_code();
        logic [31:0] c = '0;
        for (int i = ev_base; i < ev_q.size(); i++) begin
            int e = ev_q[i];
            c = (c << 4) | 32'(e & 15);
        end
        return c;
    endfunction

    function automatic int grant_count();
        int n = 0;
        for (int i = ev_base; i < ev_q.size(); i++) begin
            if (ev_q[i] == EV_GE || ev_q[i] == EV_GD) n++;
        end
        return n;
    endfunction

    function automatic logic out_valid(input logic dec);
        return dec ? dec_out.tvalid : enc_out.tvalid;
    endfunction

    function automatic logic [127:0] out_data(input logic dec);
        return dec ? dec_out.tdata : enc_out.tdata;
    endfunction

    function automatic logic side_tready(input logic dec);
        return dec ? dec_in.tready : enc_in.tready;
    endfunction

    task automatic drive_in(input logic dec, input logic v, input logic [127:0] d);
        if (dec) begin
            dec_in.tvalid = v;
            dec_in.tdata  = d;
        end else begin
            enc_in.tvalid = v;
            enc_in.tdata  = d;
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the handshake.
    task automatic send(input logic dec, input logic [127:0] d);
        bit ok = 1'b0;
        drive_in(dec, 1'b1, d);
        for (int i = 0; i < 400; i++) begin
            #1;
            if (side_tready(dec)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tmo("send_grant");
            drive_in(dec, 1'b0, d);
            return;
        end
        chk("start_low_in_handshake_cycle", eng_start, 1'b0);
        @(negedge clk);
        drive_in(dec, 1'b0, d);
    endtask

    task automatic wait_events(input int n, input string name);
        for (int i = 0; i < 600; i++) begin
            if (ev_q.size() - ev_base >= n) return;
            @(negedge clk);
        end
        tmo(name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        tmo(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_start"}, eng_start, 1'b0);
        chk({tag, "_ekey_load"}, eng_ekey_load, 1'b0);
        chk({tag, "_dkey_load"}, eng_dkey_load, 1'b0);
        chk({tag, "_enc_tvalid"}, enc_out.tvalid, 1'b0);
        chk({tag, "_dec_tvalid"}, dec_out.tvalid, 1'b0);
        chk({tag, "_enc_tready"}, enc_in.tready, 1'b0);
        chk({tag, "_dec_tready"}, dec_in.tready, 1'b0);
        chk({tag, "_eng_din"}, eng_din, 128'h0);
        chk({tag, "_eng_dec"}, eng_dec, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [127:0] held;

        vecs[0] = '{dec: 1'b0, din: PT, exp: CT};
        vecs[1] = '{dec: 1'b1, din: CT, exp: PT};
        vecs[2] = '{dec: 1'b0, din: 128'h0, exp: 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5};
        vecs[3] = '{dec: 1'b1, din: 128'h0123456789abcdef0123456789abcdef,
                    exp: 128'hfedcba9876543210fedcba9876543210};
        vecs[4] = '{dec: 1'b0, din: {128{1'b1}}, exp: 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a};

        enc_in.tvalid  = 1'b0;
        enc_in.tdata   = '0;
        dec_in.tvalid  = 1'b0;
        dec_in.tdata   = '0;
        enc_out.tready = 1'b1;
        dec_out.tready = 1'b1;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Single jobs: start one cycle after handshake, result one cycle after done.
        for (int k = 0; k < 5; k++) begin
            send(vecs[k].dec, vecs[k].din);
            chk("start_pulse", eng_start, 1'b1);
            chk("eng_dec", eng_dec, vecs[k].dec);
            chk("eng_din", eng_din, vecs[k].din);
            @(negedge clk);
            chk("start_one_cycle", eng_start, 1'b0);
            lat = 1;
            while (!eng_done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk("start_to_done", lat, ENG_LAT);
            chk("eng_dec_held", eng_dec, vecs[k].dec);
            chk("eng_din_held", eng_din, vecs[k].din);
            chk("tvalid_in_done_cycle", out_valid(vecs[k].dec), 1'b0);
            @(negedge clk);
            chk("tvalid_after_done", out_valid(vecs[k].dec), 1'b1);
            chk("result_tdata", out_data(vecs[k].dec), vecs[k].exp);
            chk("other_side_tvalid", out_valid(!vecs[k].dec), 1'b0);
            $display("vector %0d dec=%0d din=%h dout=%h", k, vecs[k].dec, vecs[k].din,
                     out_data(vecs[k].dec));
            @(negedge clk);
            chk("busy_after_out", busy, 1'b0);
            chk("tvalid_cleared", out_valid(vecs[k].dec), 1'b0);
        end

        // Both sides requesting continuously: grants alternate starting with encrypt.
        do_reset();
        ev_base = ev_q.size();
        drive_in(1'b0, 1'b1, 128'h11);
        drive_in(1'b1, 1'b1, 128'h22);
        for (int i = 0; i < 1000 && grant_count() < 4; i++) @(negedge clk);
        drive_in(1'b0, 1'b0, 128'h11);
        drive_in(1'b1, 1'b0, 128'h22);
        wait_idle("rr_idle");
        chk("rr_order", ev_code(), 32'h15261526);

        // Key update during WAIT: result first, then key load, then next grant.
        do_reset();
        ev_base = ev_q.size();
        send(1'b0, PT);
        repeat (2) @(negedge clk);
        ekey_upd = 1'b1;
        @(negedge clk);
        ekey_upd = 1'b0;
        send(1'b1, CT);
        wait_events(5, "ekey_wait_events");
        wait_idle("ekey_wait_idle");
        chk("ekey_during_wait_order", ev_code(), 32'h15326);

        // Simultaneous key updates while idle: ekey, dkey, then data.
        do_reset();
        ev_base = ev_q.size();
        ekey_upd = 1'b1;
        dkey_upd = 1'b1;
        @(negedge clk);
        ekey_upd = 1'b0;
        dkey_upd = 1'b0;
        send(1'b0, 128'h0);
        wait_events(4, "both_keys_events");
        wait_idle("both_keys_idle");
        chk("both_keys_order", ev_code(), 32'h3415);

        // Output backpressure: result held stable, no new grant, busy held.
        do_reset();
        ev_base = ev_q.size();
        dec_out.tready = 1'b0;
        send(1'b1, 128'h0123456789abcdef0123456789abcdef);
        for (int i = 0; i < 100 && !dec_out.tvalid; i++) @(negedge clk);
        drive_in(1'b0, 1'b1, 128'h33);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_tvalid", dec_out.tvalid, 1'b1);
            chk("bp_tdata", dec_out.tdata, 128'hfedcba9876543210fedcba9876543210);
            chk("bp_busy", busy, 1'b1);
            chk("bp_enc_tready", enc_in.tready, 1'b0);
            chk("bp_dec_tready", dec_in.tready, 1'b0);
        end
        dec_out.tready = 1'b1;
        wait_events(3, "bp_events");
        drive_in(1'b0, 1'b0, 128'h33);
        wait_idle("bp_idle");
        chk("bp_order", ev_code(), 32'h2615);

        // Reset in WAIT: job discarded, late done ignored.
        do_reset();
        ev_base = ev_q.size();
        send(1'b0, PT);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midjob");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("late_done_busy", busy, 1'b0);
        chk("late_done_tvalid", enc_out.tvalid, 1'b0);
        chk("late_done_events", ev_code(), 32'h1);

`ifdef AES_SCHED_TIMEOUT_EN
        // Engine never answers: watchdog returns to IDLE and sets the sticky flag.
        do_reset();
        chk("timeout_reset", timeout, 1'b0);
        ev_base = ev_q.size();
        eng_mute = 1'b1;
        send(1'b0, PT);
        wait_idle("timeout_idle");
        chk("timeout_set", timeout, 1'b1);
        chk("timeout_no_result", ev_code(), 32'h1);
        eng_mute = 1'b0;
        repeat (5) @(negedge clk);
        chk("timeout_sticky", timeout, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_engine_sched.md
AES_ENGINE_SCHED -- requirements
Module: aes_engine_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 128, AES block width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles; used only when AES_SCHED_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk  input  1  sole clock; one clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port s_axis_enc  taxi_axis_if.snk  DATA_W  plaintext jobs (tdata/tvalid/tready).
REQ-006 SHALL have port s_axis_dec  taxi_axis_if.snk  DATA_W  ciphertext jobs.
REQ-007 SHALL have port m_axis_enc  taxi_axis_if.src  DATA_W  encrypt results.
REQ-008 SHALL have port m_axis_dec  taxi_axis_if.src  DATA_W  decrypt results.
REQ-009 SHALL have port i_ekey_update / i_dkey_update  input  1 each  key-register-written pulses.
REQ-010 SHALL have port o_eng_start  output  1  one-cycle job start pulse to the shared AES engine.
REQ-011 SHALL have port o_eng_dec  output  1  engine mode: 0 encrypt, 1 decrypt; held stable from start to done.
REQ-012 SHALL have port o_eng_din  output  DATA_W  job data, held stable from start to done.
REQ-013 SHALL have port o_eng_ekey_load / o_eng_dkey_load  output  1 each  one-cycle key-expansion pulses.
REQ-014 SHALL have port i_eng_done  input  1  one-cycle completion pulse for jobs and key loads.
REQ-015 SHALL have port i_eng_dout  input  DATA_W  result, valid while i_eng_done is high.
REQ-016 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, KEY, START, WAIT, OUT.
REQ-018 SHALL set pending flags ekey_pend/dkey_pend on their update pulses; a flag clears only on its load pulse, and a pulse arriving in the same cycle as that load keeps the flag set.
REQ-019 IDLE: if any key flag is pending, SHALL go to KEY; ekey is served before dkey; no data job is granted while a flag is pending.
REQ-020 KEY: SHALL pulse exactly one load output on entry, wait for i_eng_done, then return to IDLE.
REQ-021 IDLE with no key pending: SHALL grant round-robin between tvalid requesters; the pointer favours the side not served last; after reset the favoured side is encrypt.
REQ-022 tready SHALL be high only in IDLE, only for the granted side, and only for one cycle; it may depend combinationally on tvalid.
REQ-023 On handshake in cycle N: SHALL register tdata and mode, and go to START; o_eng_start SHALL pulse in cycle N+1, then go to WAIT.
REQ-024 WAIT: on i_eng_done in cycle D, SHALL capture i_eng_dout and assert the matching m_axis tvalid in cycle D+1 (state OUT).
REQ-025 OUT: SHALL hold tvalid and tdata until tready, then return to IDLE and update the round-robin pointer.
REQ-026 SHALL ignore i_eng_done in IDLE, START and OUT.
REQ-027 Key update pulses arriving during START/WAIT/OUT SHALL be latched and served before the next data grant.

Reset
REQ-028 On rst, SHALL enter IDLE with all tready=0, tvalid=0, o_eng_start=0, both load outputs=0, o_busy=0, and pending flags=0; data registers SHALL be 0.
REQ-029 A reset mid-job SHALL discard the job with no result emitted.

Configuration
REQ-030 With AES_SCHED_TIMEOUT_EN defined: a counter SHALL run in WAIT and KEY; on reaching TIMEOUT_CYC without i_eng_done, the FSM SHALL return to IDLE with no output, and a sticky output o_timeout SHALL be set (cleared only by rst).
REQ-031 Without AES_SCHED_TIMEOUT_EN: no counter and no o_timeout port; WAIT and KEY SHALL wait indefinitely.

Structure
REQ-032 SHALL place the state enum and the mode enum (ENC=0, DEC=1) in shared package aes_sched_pkg.
REQ-033 SHALL implement round-robin arbitration in sub-module aes_rr_arb2 (2 requests, grant, pointer-update input).

Verification
REQ-034 Single encrypt job with tdata=128'h00112233445566778899aabbccddeeff: start pulse 1 cycle after handshake; with the engine model done after 10 cycles returning 128'h69c4e0d8..., m_axis_enc tvalid follows 1 cycle after done.
REQ-035 Encrypt and decrypt tvalid both high continuously for 4 jobs: grants alternate ENC, DEC, ENC, DEC.
REQ-036 i_ekey_update pulsed during WAIT: result delivered first, then o_eng_ekey_load pulses before the next data tready.
REQ-037 ekey and dkey updates in the same cycle while idle: ekey load, done, dkey load, done, then data grant.
REQ-038 m_axis_dec tready held low 20 cycles: tvalid and tdata stay stable, no new tready is issued, and o_busy stays 1.
REQ-039 rst asserted in WAIT: next cycle all outputs are at reset values; a late i_eng_done is ignored (timeout variant: no done for TIMEOUT_CYC sets o_timeout).
